// File: rtl/data_ram_arbiter_pkg.sv
// Shared types and pin-level constants for the data RAM arbiter and its grant picker.
package data_ram_arbiter_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_RESP   = 2'd2
    } arb_state_e;

    localparam logic MASTER0 = 1'b0;
    localparam logic MASTER1 = 1'b1;

    localparam logic CHIP_DISABLE  = 1'b0;
    localparam logic CHIP_ENABLE   = 1'b1;
    localparam logic WRITE_DISABLE = 1'b0;
    localparam logic WRITE_ENABLE  = 1'b1;

    localparam logic [DATA_W-1:0] ZERO_WORD = '0;

endpackage

// File: rtl/data_ram_rr_pick.sv
// Combinational grant picker: a live lock wins outright, otherwise round-robin on last_gnt.
module data_ram_rr_pick
    import data_ram_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_gnt,
    input  logic       lock_valid,
    input  logic       lock_owner,
    output logic       gnt_valid,
    output logic       gnt_id
);

    always_comb begin
        gnt_valid = 1'b0;
        gnt_id    = MASTER0;
        // A lock whose owner has gone quiet no longer blocks the other master.
        if (lock_valid && req[lock_owner]) begin
            gnt_valid = 1'b1;
            gnt_id    = lock_owner;
        end else if (req == 2'b11) begin
            gnt_valid = 1'b1;
            gnt_id    = ~last_gnt;
        end else if (req[0]) begin
            gnt_valid = 1'b1;
            gnt_id    = MASTER0;
        end else if (req[1]) begin
            gnt_valid = 1'b1;
            gnt_id    = MASTER1;
        end
    end

endmodule

// File: rtl/data_ram_arbiter.sv
// Two-master arbiter and access sequencer for the 32-bit data RAM; all RAM pins are registered.
//   state      | meaning
//   ARB_IDLE   | arbitrate, latch winner, load RAM pins or flag range error
//   ARB_ACCESS | RAM pins stable; write commits / read captured at closing edge
//   ARB_RESP   | one-cycle ack (and err) to the owner, requests ignored
module data_ram_arbiter
    import data_ram_arbiter_pkg::*;
#(
    parameter int ADDR_W   = 17,
    parameter int DEPTH    = 131071,
    parameter int MAX_LOCK = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic              m0_lock,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_data_i,
    output logic              m0_ack,
    output logic              m0_err,
    output logic [DATA_W-1:0] m0_data_o,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic              m1_lock,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_data_i,
    output logic              m1_ack,
    output logic              m1_err,
    output logic [DATA_W-1:0] m1_data_o,
    output logic              ram_ce,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data_o,
    input  logic [DATA_W-1:0] ram_data_i
);

    localparam int               CNT_W     = $clog2(MAX_LOCK + 1);
    localparam logic [ADDR_W:0]  DEPTH_V   = (ADDR_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(MAX_LOCK - 1);

    arb_state_e       state;
    logic             owner;
    logic             own_we;
    logic             own_lock;
    logic             last_gnt;
    logic             lock_valid;
    logic             lock_owner;
    logic [CNT_W-1:0] lock_cnt;

    logic              gnt_valid;
    logic              gnt_id;
    logic              sel_we;
    logic              sel_lock;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;
    logic              sel_in_range;

    logic             enter_resp;
    logic             ent_owner;
    logic             ent_lock;
    logic             ent_err;
    logic             ent_read;
    logic             lock_keep;
    logic [CNT_W-1:0] cnt_base;

    data_ram_rr_pick u_pick (
        .req        ({m1_req, m0_req}),
        .last_gnt   (last_gnt),
        .lock_valid (lock_valid),
        .lock_owner (lock_owner),
        .gnt_valid  (gnt_valid),
        .gnt_id     (gnt_id)
    );

    always_comb begin
        if (gnt_id == MASTER1) begin
            sel_we   = m1_we;
            sel_lock = m1_lock;
            sel_addr = m1_addr;
            sel_data = m1_data_i;
        end else begin
            sel_we   = m0_we;
            sel_lock = m0_lock;
            sel_addr = m0_addr;
            sel_data = m0_data_i;
        end
        sel_in_range = ({1'b0, sel_addr} < DEPTH_V);
    end

    // Response entry happens either from ACCESS or straight from IDLE on a range error.
    always_comb begin
        enter_resp = 1'b0;
        ent_owner  = owner;
        ent_lock   = own_lock;
        ent_err    = 1'b0;
        ent_read   = !own_we;
        if (state == ARB_IDLE) begin
            enter_resp = gnt_valid && !sel_in_range;
            ent_owner  = gnt_id;
            ent_lock   = sel_lock;
            ent_err    = 1'b1;
            ent_read   = 1'b0;
        end else if (state == ARB_ACCESS) begin
            enter_resp = 1'b1;
        end
        cnt_base  = (lock_valid && (lock_owner == ent_owner)) ? lock_cnt : '0;
        lock_keep = ent_lock && (cnt_base < LOCK_LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ARB_IDLE;
            owner      <= MASTER0;
            own_we     <= 1'b0;
            own_lock   <= 1'b0;
            last_gnt   <= MASTER1;
            lock_valid <= 1'b0;
            lock_owner <= MASTER0;
            lock_cnt   <= '0;
            ram_ce     <= CHIP_DISABLE;
            ram_we     <= WRITE_DISABLE;
            ram_addr   <= '0;
            ram_data_o <= ZERO_WORD;
            m0_ack     <= 1'b0;
            m0_err     <= 1'b0;
            m0_data_o  <= ZERO_WORD;
            m1_ack     <= 1'b0;
            m1_err     <= 1'b0;
            m1_data_o  <= ZERO_WORD;
        end else begin
            m0_ack <= 1'b0;
            m0_err <= 1'b0;
            m1_ack <= 1'b0;
            m1_err <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    if (lock_valid && !(lock_owner ? m1_req : m0_req)) begin
                        lock_valid <= 1'b0;
                        lock_cnt   <= '0;
                    end
                    if (gnt_valid) begin
                        owner    <= gnt_id;
                        own_we   <= sel_we;
                        own_lock <= sel_lock;
                        last_gnt <= gnt_id;
                        if (sel_in_range) begin
                            ram_ce     <= CHIP_ENABLE;
                            ram_we     <= sel_we ? WRITE_ENABLE : WRITE_DISABLE;
                            ram_addr   <= sel_addr;
                            ram_data_o <= sel_data;
                            state      <= ARB_ACCESS;
                        end else begin
                            state <= ARB_RESP;
                        end
                    end
                end
                ARB_ACCESS: begin
                    ram_ce <= CHIP_DISABLE;
                    ram_we <= WRITE_DISABLE;
                    state  <= ARB_RESP;
                end
                ARB_RESP: state <= ARB_IDLE;
                default:  state <= ARB_IDLE;
            endcase

            if (enter_resp) begin
                if (ent_owner == MASTER0) begin
                    m0_ack <= 1'b1;
                    m0_err <= ent_err;
                    if (ent_err)       m0_data_o <= ZERO_WORD;
                    else if (ent_read) m0_data_o <= ram_data_i;
                end else begin
                    m1_ack <= 1'b1;
                    m1_err <= ent_err;
                    if (ent_err)       m1_data_o <= ZERO_WORD;
                    else if (ent_read) m1_data_o <= ram_data_i;
                end
                if (lock_keep) begin
                    lock_valid <= 1'b1;
                    lock_owner <= ent_owner;
                    lock_cnt   <= cnt_base + CNT_W'(1);
                end else begin
                    lock_valid <= 1'b0;
                    lock_cnt   <= '0;
                    last_gnt   <= ent_owner;
                end
            end
        end
    end

endmodule
